dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the pipelined RISC-V core: the target side of the MEM-stage load/store interface. It accepts one load or store per transaction, models a configurable access latency with a stall (`busy`) handshake, and performs byte/half/word lane selection, sign/zero extension and byte-lane writes per `funct3`. It sits between the EX/MEM pipeline register outputs (read enable, write enable, address, store data, `funct3`) and the MEM/WB register's read-data input.

## Interface
- `ADDR_W`, 9: byte address width.
- `DATA_W`, 32: data width; fixed at 32, with 4 byte lanes.
- `DEPTH`, 128: number of 32-bit words; word index is `req_addr[ADDR_W-1:2]`.
- `LAT`, 2: wait cycles between acceptance and response; legal range 0..7.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `req_read`  in  1  load request; held stable by the pipeline while `busy`=1.
- `req_write`  in  1  store request; same stability rule.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data; the low byte/half is used for `sb`/`sh`.
- `req_funct3`  in  3  size code: 000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu are loads only).
- `busy`  out  1  stall request to the pipeline.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_err`  out  1  qualifies `resp_valid`: misaligned or illegal request.
- `resp_rdata`  out  DATA_W  extended load data; holds its value until the next load response.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**, with a request (`req_read`|`req_write`):
  - Latch op, address, data and `funct3`.
  - Go to WAIT, or to DONE if `LAT`=0.
  - Load the wait counter with `LAT`-1.
- **WAIT:** decrement the counter. At zero, go to DONE.
- **Commit:** on the clock edge entering DONE:
  - Stores write the selected lanes.
  - Loads register the extracted value into `resp_rdata`.
- **DONE:** `resp_valid`=1, `busy`=0. Next state is always IDLE. Inputs seen in DONE are not accepted, because they are the request just served.
- **Errors:** a request is an error, with no array access, if any of the following holds:
  - the half address is odd;
  - the word address is not a multiple of 4 (`addr[1:0]`≠0);
  - `funct3` is not a legal value for the op;
  - both `req_read` and `req_write` are 1.

  An error request goes IDLE→DONE directly, with `resp_err`=1. `resp_rdata` is unchanged.
- **Lane mapping (little-endian):**
  - b: lane `addr[1:0]`.
  - h: lanes `{addr[1],0}` and `{addr[1],1}`.
  - Loads with `funct3` 000/001 sign-extend; 100/101 zero-extend.
- **Array:** no reset. Contents are undefined until written, and reset does not clear them.

## Timing
- `busy` is combinational: 1 in IDLE while a request is present, and 1 in WAIT. It is 0 in DONE and in idle IDLE.
- A request first seen in IDLE at cycle t:
  - `busy` is high for cycles t..t+`LAT`.
  - DONE is at t+`LAT`+1.
  - The stall is `LAT`+1 cycles.
- Error request seen at cycle t: `busy` is high for cycle t only; `resp_valid`=`resp_err`=1 at t+1.
- Back-to-back requests: the next request is accepted no earlier than the cycle after DONE. Maximum throughput is one transaction per `LAT`+2 cycles.
- Reset low, at any time including WAIT:
  - State goes to IDLE immediately.
  - `busy`, `resp_valid`, `resp_err` and `resp_rdata` all go to 0.
  - An uncommitted store is dropped.
  - The first acceptance can occur at the first rising edge after reset returns to 1.

## Structure
- Package `dmem_pkg`:
  - `funct3` localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum typedef `dmem_state_e`.
  - Request struct `dmem_req_t` (op, addr, wdata, funct3).
- Sub-module `dmem_load_align`, combinational:
  - Inputs: word, `addr[1:0]`, `funct3`.
  - Output: extended load value.
  - Also produces the 4-bit write byte-enable and the lane-replicated store data.

## Test plan
All scenarios use `LAT`=2 unless noted.
1. `sw` 0x010 ← 0xDEADBEEF, then `lw` 0x010 -> `busy` is high for 3 cycles each; `resp_valid` at t+3; `resp_rdata`=0xDEADBEEF, `resp_err`=0.
2. `sw` 0x010 ← 0x11223344; then `sb` 0x013 ← 0x000000A5 -> `lw` returns 0xA5223344; `lb` 0x013 returns 0xFFFFFFA5; `lbu` 0x013 returns 0x000000A5.
3. `sh` 0x012 ← 0x00008001 -> `lh` 0x012 returns 0xFFFF8001; `lhu` returns 0x00008001; `lw` 0x010 returns 0x80013344.
4. `lw` 0x006, `sh` 0x011, `sb` with `funct3`=100, and read+write together -> each gives one `busy` cycle then `resp_valid`=`resp_err`=1; a later `lw` 0x010 shows unchanged data and `resp_rdata` is not updated.
5. Start `sw` 0x020 ← 0xCAFEF00D after a prior `sw` 0x020 ← 0x0; drive reset low during WAIT -> all outputs go to 0 immediately; after release, `lw` 0x020 returns 0x00000000.
6. `LAT`=0 build: a store and load to 0x1FC, issued back-to-back as fast as allowed -> one `busy` cycle, response at t+1, accepts on alternate cycles, `lw` returns the stored value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Holds the funct3 size codes, FSM state, request record and request legality check.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 9;
   localparam int DMEM_DATA_W = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_STORE = 1'b1
   } dmem_op_e;

   typedef struct packed {
      dmem_op_e               op;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
      logic [2:0]             funct3;
   } dmem_req_t;

   // True when the request must be answered with resp_err and no array access.
   function automatic logic req_is_err(input logic       rd,
                                       input logic       wr,
                                       input logic [1:0] addr_lo,
                                       input logic [2:0] f3);
      logic err;
      err = 1'b0;
      if (rd && wr) begin
         err = 1'b1;
      end else if (rd) begin
         case (f3)
            F3_B, F3_BU: err = 1'b0;
            F3_H, F3_HU: err = addr_lo[0];
            F3_W:        err = |addr_lo;
            default:     err = 1'b1;
         endcase
      end else begin
         case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_lo[0];
            F3_W:    err = |addr_lo;
            default: err = 1'b1;
         endcase
      end
      return err;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Little-endian lane steering: load extraction with sign/zero extension,
// plus store byte-enables and lane-replicated store data.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [3:0]  byte_en_o,
   output logic [31:0] wdata_rep_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = '0;
      case (addr_lo_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      load_data_o = word_i;
      byte_en_o   = 4'b0000;
      wdata_rep_o = wdata_i;
      case (funct3_i)
         F3_B: begin
            load_data_o = {{24{byte_sel[7]}}, byte_sel};
            byte_en_o   = 4'b0001 << addr_lo_i;
            wdata_rep_o = {4{wdata_i[7:0]}};
         end
         F3_BU: load_data_o = {24'd0, byte_sel};
         F3_H: begin
            load_data_o = {{16{half_sel[15]}}, half_sel};
            byte_en_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_rep_o = {2{wdata_i[15:0]}};
         end
         F3_HU: load_data_o = {16'd0, half_sel};
         F3_W:  byte_en_o   = 4'b1111;
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Target side of the MEM-stage load/store port: accepts one request, stalls for
// LAT wait cycles, commits on the edge into DONE and strobes a one-cycle response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W,
   parameter int DEPTH  = 128,
   parameter int LAT    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [2:0]        req_funct3,
   output logic              busy,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [DATA_W-1:0] resp_rdata,
   output dmem_state_e       dbg_state
);

   // Handshake: the pipeline holds req_* stable while busy=1; resp_valid is a
   // single-cycle strobe in DONE, qualified by resp_err; a request is taken only in IDLE.

   dmem_state_e       state_q;
   logic [2:0]        cnt_q;
   dmem_req_t         req_q;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic [DATA_W-1:0] rdata_q;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              req_any;
   logic              in_err;
   dmem_req_t         in_req;
   dmem_req_t         cmt_req;
   logic [ADDR_W-3:0] word_idx;
   logic [31:0]       rd_word;
   logic [31:0]       load_data;
   logic [3:0]        byte_en;
   logic [31:0]       wdata_rep;
   logic              commit;
   logic              mem_we;

   assign req_any = req_read | req_write;
   assign in_err  = req_is_err(req_read, req_write, req_addr[1:0], req_funct3);
   assign in_req  = '{op: (req_write ? OP_STORE : OP_LOAD), addr: req_addr,
                      wdata: req_wdata, funct3: req_funct3};

   // With LAT=0 the commit edge is the acceptance edge, so the live inputs are used.
   assign cmt_req  = (state_q == IDLE) ? in_req : req_q;
   assign word_idx = cmt_req.addr[ADDR_W-1:2];
   assign rd_word  = mem_q[word_idx];

   dmem_load_align u_align (
      .word_i      (rd_word),
      .addr_lo_i   (cmt_req.addr[1:0]),
      .funct3_i    (cmt_req.funct3),
      .wdata_i     (cmt_req.wdata),
      .load_data_o (load_data),
      .byte_en_o   (byte_en),
      .wdata_rep_o (wdata_rep)
   );

   assign commit = reset &&
                   (((state_q == IDLE) && req_any && !in_err && (LAT == 0)) ||
                    ((state_q == WAIT) && (cnt_q == 3'd0)));
   assign mem_we = commit && (cmt_req.op == OP_STORE);

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         req_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rdata_q      <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_any) begin
                  req_q <= in_req;
                  if (in_err) begin
                     state_q      <= DONE;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                  end else if (LAT == 0) begin
                     state_q      <= DONE;
                     resp_valid_q <= 1'b1;
                     if (in_req.op == OP_LOAD) rdata_q <= load_data;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= 3'(LAT - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 3'd0) begin
                  state_q      <= DONE;
                  resp_valid_q <= 1'b1;
                  if (req_q.op == OP_LOAD) rdata_q <= load_data;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = reset && (((state_q == IDLE) && req_any) || (state_q == WAIT));
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = rdata_q;
   assign dbg_state  = state_q;

endmodule
